// File: rtl/mmr_intr_pkg.sv
// Shared constants and types for the interrupt status/mask register block.
package mmr_intr_pkg;

  // Register offsets within one source's 4-word window (addr[1:0]).
  localparam logic [1:0] MMR_INTR_ISR     = 2'd0;
  localparam logic [1:0] MMR_INTR_IMR     = 2'd1;
  localparam logic [1:0] MMR_INTR_IMR_SET = 2'd2;
  localparam logic [1:0] MMR_INTR_IMR_CLR = 2'd3;

  // Register-port access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mmr_intr_interface.sv
// Bundle between the interrupt event producers (master) and the
// register-side controller (slave).
interface mmr_intr_interface #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  logic [N-1:0][WIDTH-1:0] isr_pulses;
  logic [N-1:0][WIDTH-1:0] isr;
  logic [N-1:0][WIDTH-1:0] imr;
  logic [N-1:0]            interrupts;

  modport slave  (input isr_pulses, output isr, output imr, output interrupts);
  modport master (output isr_pulses, input isr, input imr, input interrupts);
endinterface

// File: rtl/mmr_intr_bank.sv
// Status/mask storage for a single interrupt source.
module mmr_intr_bank #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pulses,
  input  logic [WIDTH-1:0] w1c,
  input  logic             imr_we,
  input  logic             imr_set,
  input  logic             imr_clr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] isr,
  output logic [WIDTH-1:0] imr,
  output logic             irq
);

  // Sticky status: software clears via W1C, a same-cycle pulse wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) isr <= '0;
    else       isr <= (isr & ~w1c) | pulses;
  end

  // Mask register: full write, bitwise set, or bitwise clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        imr <= '0;
    else if (imr_we)  imr <= wdata;
    else if (imr_set) imr <= imr | wdata;
    else if (imr_clr) imr <= imr & ~wdata;
  end

  assign irq = |(isr & imr);

endmodule

// File: rtl/mmr_intr_ctrl.sv
// Interrupt controller: register-port decode, access sequencer and read mux
// in front of one status/mask bank per source.
//
// Register port handshake: the requester raises reg_req with reg_we,
// reg_addr and reg_wdata stable and holds them until it sees reg_ack.
// reg_ack is a single-cycle pulse, one cycle after reg_req is first seen in
// IDLE; reg_rdata is valid only in that cycle. A new access is accepted only
// after reg_req has been observed low, so each request yields one access.
module mmr_intr_ctrl
  import mmr_intr_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int WIDTH  = 32,
  localparam int ADDR_W = $clog2(N) + 2
) (
  input  logic              clock,
  input  logic              reset,
  mmr_intr_interface.slave  intr,
  input  logic              reg_req,
  input  logic              reg_we,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [WIDTH-1:0]  reg_wdata,
  output logic              reg_ack,
  output logic [WIDTH-1:0]  reg_rdata,
  output logic [1:0]        fsm_state
);

  acc_state_e        state;
  logic              access;
  logic [ADDR_W-1:0] src;
  logic [1:0]        reg_sel;
  logic [N-1:0]      wr_hit;
  logic [WIDTH-1:0]  rd_val;
  logic [WIDTH-1:0]  isr_q [N];
  logic [WIDTH-1:0]  imr_q [N];
  logic [N-1:0]      irq;

  // An access is performed only in the cycle the request is seen in IDLE.
  assign access  = (state == IDLE) && reg_req;
  assign src     = reg_addr >> 2;
  assign reg_sel = reg_addr[1:0];

  // Per-source write select; sources at or beyond N never match.
  always_comb begin
    wr_hit = '0;
    for (int s = 0; s < N; s++) begin
      wr_hit[s] = access && reg_we && (src == ADDR_W'(s));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_bank
    mmr_intr_bank #(.WIDTH(WIDTH)) u_bank (
      .clock   (clock),
      .reset   (reset),
      .pulses  (intr.isr_pulses[g]),
      .w1c     ((wr_hit[g] && reg_sel == MMR_INTR_ISR) ? reg_wdata : '0),
      .imr_we  (wr_hit[g] && reg_sel == MMR_INTR_IMR),
      .imr_set (wr_hit[g] && reg_sel == MMR_INTR_IMR_SET),
      .imr_clr (wr_hit[g] && reg_sel == MMR_INTR_IMR_CLR),
      .wdata   (reg_wdata),
      .isr     (isr_q[g]),
      .imr     (imr_q[g]),
      .irq     (irq[g])
    );
  end

  // Present bank state on the interface.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      intr.isr[s] = isr_q[s];
      intr.imr[s] = imr_q[s];
    end
  end

  assign intr.interrupts = irq;

  // Read mux over registered state, so pulses of the read cycle are not seen.
  always_comb begin
    rd_val = '0;
    for (int s = 0; s < N; s++) begin
      if (src == ADDR_W'(s)) begin
        case (reg_sel)
          MMR_INTR_ISR: rd_val = isr_q[s];
          MMR_INTR_IMR: rd_val = imr_q[s];
          default:      rd_val = '0;
        endcase
      end
    end
  end

  // Access sequencer with registered ack and read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reg_req) begin
            state     <= ACK;
            reg_ack   <= 1'b1;
            reg_rdata <= reg_we ? '0 : rd_val;
          end
        end
        ACK: begin
          state     <= WAIT;
          reg_ack   <= 1'b0;
          reg_rdata <= '0;
        end
        WAIT: begin
          if (!reg_req) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          reg_ack   <= 1'b0;
          reg_rdata <= '0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_mmr_intr_ctrl.sv
// Bench for mmr_intr_ctrl: directed scenarios followed by randomized
// accesses and pulses, checked against a behavioural register model.
module tb_mmr_intr_ctrl;
  import mmr_intr_pkg::*;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int AW = $clog2(N) + 2;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic          reg_req;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [W-1:0]  reg_wdata;
  logic          reg_ack;
  logic [W-1:0]  reg_rdata;
  logic [1:0]    fsm_state;

  always #5 clock = ~clock;

  mmr_intr_interface #(.N(N), .WIDTH(W)) intr_if ();

  mmr_intr_ctrl #(.N(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .intr      (intr_if.slave),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata),
    .fsm_state (fsm_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]        m_isr [N];
  logic [W-1:0]        m_imr [N];
  logic [W-1:0]        exp_q [$];
  logic [W-1:0]        last_rdata;
  logic [N-1:0][W-1:0] req_pulses;
  bit                  acc_now;
  bit                  rand_pulses;
  int                  n_vec;
  int                  n_err;

  function automatic logic [AW-1:0] addr_of(input int s, input logic [1:0] r);
    return AW'(s * 4 + int'(r));
  endfunction

  // Register contents a read at address a returns.
  function automatic logic [W-1:0] model_read(input logic [AW-1:0] a);
    int s;
    int r;
    s = int'(a) / 4;
    r = int'(a) % 4;
    if (s >= N) return '0;
    if (r == 0) return m_isr[s];
    if (r == 1) return m_imr[s];
    return '0;
  endfunction

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_edge();
    int as;
    int ar;
    logic [W-1:0] clr;
    as = int'(reg_addr) / 4;
    ar = int'(reg_addr) % 4;
    for (int s = 0; s < N; s++) begin
      clr = '0;
      if (acc_now && reg_we && as == s) begin
        if (ar == 0)      clr = reg_wdata;
        else if (ar == 1) m_imr[s] = reg_wdata;
        else if (ar == 2) m_imr[s] = m_imr[s] | reg_wdata;
        else              m_imr[s] = m_imr[s] & ~reg_wdata;
      end
      m_isr[s] = (m_isr[s] & ~clr) | intr_if.isr_pulses[s];
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    for (int s = 0; s < N; s++) begin
      check($sformatf("isr%0d", s), intr_if.isr[s], m_isr[s]);
      check($sformatf("imr%0d", s), intr_if.imr[s], m_imr[s]);
      check($sformatf("irq%0d", s), intr_if.interrupts[s], |(m_isr[s] & m_imr[s]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic step();
    if (rand_pulses) begin
      for (int s = 0; s < N; s++)
        intr_if.isr_pulses[s] = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
    end
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_state();
  endtask

  task automatic access(input logic we, input logic [AW-1:0] addr,
                        input logic [W-1:0] wdata, input int hold);
    reg_req   = 1'b1;
    reg_we    = we;
    reg_addr  = addr;
    reg_wdata = wdata;
    if (!rand_pulses) intr_if.isr_pulses = req_pulses;
    exp_q.push_back(we ? '0 : model_read(addr));
    acc_now = 1'b1;
    step();
    acc_now = 1'b0;
    if (!rand_pulses) intr_if.isr_pulses = '0;
    req_pulses = '0;
    last_rdata = reg_rdata;
    check("ack_rise", reg_ack, 1);
    check("rdata", reg_rdata, exp_q.pop_front());
    for (int i = 1; i < hold; i++) begin
      step();
      check("ack_hold", reg_ack, 0);
      check("rdata_idle", reg_rdata, 0);
    end
    reg_req = 1'b0;
    reg_we  = 1'b0;
    repeat (2) begin
      step();
      check("ack_low", reg_ack, 0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset      = 1'b1;
    reg_req    = 1'b0;
    reg_we     = 1'b0;
    reg_addr   = '0;
    reg_wdata  = '0;
    intr_if.isr_pulses = '0;
    req_pulses = '0;
    acc_now    = 1'b0;
    rand_pulses = 1'b0;
    n_vec      = 0;
    n_err      = 0;
    last_rdata = '0;
    for (int s = 0; s < N; s++) begin
      m_isr[s] = '0;
      m_imr[s] = '0;
    end

    // Reset values
    #1;
    check("rst_ack", reg_ack, 0);
    check("rst_rdata", reg_rdata, 0);
    check("rst_fsm", fsm_state, IDLE);
    check_state();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Pulse on a masked source, then unmask it
    intr_if.isr_pulses[1] = 32'h10;
    step();
    intr_if.isr_pulses = '0;
    check("isr1_set", intr_if.isr[1], 32'h10);
    check("irq1_masked", intr_if.interrupts[1], 0);
    access(1'b0, addr_of(1, MMR_INTR_ISR), '0, 1);
    check("rd_isr1", last_rdata, 32'h10);
    access(1'b1, addr_of(1, MMR_INTR_IMR_SET), 32'h10, 1);
    check("irq1_unmasked", intr_if.interrupts[1], 1);

    // W1C racing a pulse on the same bit
    intr_if.isr_pulses[2] = 32'h3;
    step();
    intr_if.isr_pulses = '0;
    access(1'b1, addr_of(2, MMR_INTR_IMR_SET), 32'h1, 1);
    req_pulses[2] = 32'h1;
    access(1'b1, addr_of(2, MMR_INTR_ISR), 32'h3, 1);
    check("isr2_race", intr_if.isr[2], 32'h1);
    check("irq2_race", intr_if.interrupts[2], 1);
    access(1'b0, addr_of(2, MMR_INTR_ISR), '0, 1);
    check("rd_isr2", last_rdata, 32'h1);

    // IMR write / clear / set
    access(1'b1, addr_of(0, MMR_INTR_IMR), 32'hF0, 1);
    access(1'b1, addr_of(0, MMR_INTR_IMR_CLR), 32'h30, 1);
    access(1'b1, addr_of(0, MMR_INTR_IMR_SET), 32'h01, 1);
    access(1'b0, addr_of(0, MMR_INTR_IMR), '0, 1);
    check("rd_imr0", last_rdata, 32'hC1);
    access(1'b0, addr_of(0, MMR_INTR_IMR_SET), '0, 1);
    check("rd_imr_set0", last_rdata, 0);
    access(1'b0, addr_of(0, MMR_INTR_IMR_CLR), '0, 1);
    check("rd_imr_clr0", last_rdata, 0);

    // Long-held request: a single ack
    access(1'b0, addr_of(1, MMR_INTR_ISR), '0, 5);
    check("rd_isr1_hold", last_rdata, 32'h10);

    // Out-of-range source
    access(1'b0, addr_of(3, MMR_INTR_ISR), '0, 1);
    check("rd_oor", last_rdata, 0);
    access(1'b1, addr_of(3, MMR_INTR_IMR), 32'hFFFF_FFFF, 2);
    access(1'b1, addr_of(3, MMR_INTR_ISR), 32'hFFFF_FFFF, 1);
    check("oor_imr0", intr_if.imr[0], 32'hC1);
    check("oor_isr1", intr_if.isr[1], 32'h10);

    // Randomized traffic
    rand_pulses = 1'b1;
    repeat (150) begin
      access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), W'($urandom),
             $urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) step();
    end
    rand_pulses = 1'b0;
    intr_if.isr_pulses = '0;

    // Reset in the middle of an access
    access(1'b1, addr_of(0, MMR_INTR_IMR), 32'hFFFF_FFFF, 1);
    intr_if.isr_pulses[0] = 32'hA5;
    step();
    intr_if.isr_pulses = '0;
    reg_req   = 1'b1;
    reg_we    = 1'b0;
    reg_addr  = addr_of(0, MMR_INTR_ISR);
    reg_wdata = '0;
    acc_now   = 1'b1;
    step();
    acc_now   = 1'b0;
    check("ack_pre_reset", reg_ack, 1);
    #2;
    reset = 1'b1;
    #1;
    for (int s = 0; s < N; s++) begin
      m_isr[s] = '0;
      m_imr[s] = '0;
    end
    check("mid_rst_ack", reg_ack, 0);
    check("mid_rst_rdata", reg_rdata, 0);
    check("mid_rst_fsm", fsm_state, IDLE);
    check_state();
    reg_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    access(1'b0, addr_of(0, MMR_INTR_ISR), '0, 1);
    check("rd_isr0_post_rst", last_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
